// File: rtl/game_sequencer_if.sv
// Bundle of the game sequencer's pulse inputs and registered status outputs.
// tick_1hz, start and hit are single-cycle pulses sampled on every rising clk edge.
// There is no back-pressure, so every pulse is either consumed or deliberately ignored.
interface game_sequencer_if #(
    parameter int SCORE_W = 16
);
    logic               tick_1hz;
    logic               start;
    logic               hit;
    logic [1:0]         phase;
    logic [5:0]         seconds_left;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;
    logic               moles_enable;
    logic [31:0]        display_value;

    modport master (
        output tick_1hz, start, hit,
        input  phase, seconds_left, score, high_score, new_high, moles_enable, display_value
    );

    modport slave (
        input  tick_1hz, start, hit,
        output phase, seconds_left, score, high_score, new_high, moles_enable, display_value
    );
endinterface

// File: rtl/game_sequencer.sv
// Whack-a-mole phase sequencer: idle, countdown, timed play and game-over.
// It also tracks the round score and the session high score. Every output is a flop.
module game_sequencer #(
    parameter int COUNTDOWN_SEC = 5,
    parameter int GAME_SEC      = 30,
    parameter int SCORE_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        COUNTDOWN = 2'b00,
        PLAY      = 2'b01,
        OVER      = 2'b10,
        IDLE      = 2'b11
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t             state_q, state_d;
    logic [5:0]         secs_q, secs_d;
    logic [SCORE_W-1:0] score_q, score_d, score_inc;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic               nh_q, nh_d;
    logic               moles_q, moles_d;
    logic [31:0]        disp_q, disp_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            secs_q  <= '0;
            score_q <= '0;
            hi_q    <= '0;
            nh_q    <= 1'b0;
            moles_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            score_q <= score_d;
            hi_q    <= hi_d;
            nh_q    <= nh_d;
            moles_q <= moles_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        score_d   = score_q;
        hi_d      = hi_q;
        nh_d      = nh_q;
        score_inc = (bus.hit && score_q != SCORE_MAX) ? score_q + 1'b1 : score_q;

        unique case (state_q)
            IDLE, OVER: begin
                // A start in the same cycle as a tick wins; the tick is simply dropped.
                if (bus.start) begin
                    state_d = COUNTDOWN;
                    secs_d  = 6'(COUNTDOWN_SEC);
                    score_d = '0;
                    nh_d    = 1'b0;
                end
            end
            COUNTDOWN: begin
                if (bus.tick_1hz) begin
                    if (secs_q == 6'd1) begin
                        state_d = PLAY;
                        secs_d  = 6'(GAME_SEC);
                    end else begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end
            PLAY: begin
                score_d = score_inc;
                if (bus.tick_1hz) begin
                    if (secs_q == 6'd1) begin
                        state_d = OVER;
                        secs_d  = 6'd0;
                        // Compare the post-hit score so a last-instant hit can set the record.
                        if (score_inc > hi_q) begin
                            hi_d = score_inc;
                            nh_d = 1'b1;
                        end
                    end else begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        moles_d = (state_d == PLAY);
        disp_d  = '0;
        unique case (state_d)
            COUNTDOWN:  disp_d[5:0]         = secs_d;
            PLAY, OVER: disp_d[SCORE_W-1:0] = score_d;
            default:    disp_d[SCORE_W-1:0] = hi_d;
        endcase
    end

    assign bus.phase         = state_q;
    assign bus.seconds_left  = secs_q;
    assign bus.score         = score_q;
    assign bus.high_score    = hi_q;
    assign bus.new_high      = nh_q;
    assign bus.moles_enable  = moles_q;
    assign bus.display_value = disp_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a default-width instance for the full game flow
// and a 3-bit-score instance for saturation.
module tb_game_sequencer;
    localparam logic [1:0] P_CD = 2'b00, P_PLAY = 2'b01, P_OVER = 2'b10, P_IDLE = 2'b11;
    localparam int EW = 2 + 6 + 16 + 16 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [EW-1:0] exp_q[$];
    logic [4:0]    exp_b_q[$];

    game_sequencer_if #(.SCORE_W(16)) a_if ();
    game_sequencer_if #(.SCORE_W(3))  b_if ();

    game_sequencer #(.COUNTDOWN_SEC(5), .GAME_SEC(30), .SCORE_W(16)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (a_if.slave)
    );

    game_sequencer #(.COUNTDOWN_SEC(2), .GAME_SEC(3), .SCORE_W(3)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        logic [EW-1:0] e;
        logic [1:0]    ep;
        logic [5:0]    es;
        logic [15:0]   esc, ehi;
        logic          enh;
        logic [31:0]   edisp;
        e = exp_q.pop_front();
        {ep, es, esc, ehi, enh} = e;
        edisp = (ep == P_CD) ? {26'd0, es} : (ep == P_IDLE) ? {16'd0, ehi} : {16'd0, esc};
        chk("phase",         {30'd0, a_if.phase},        {30'd0, ep});
        chk("seconds_left",  {26'd0, a_if.seconds_left}, {26'd0, es});
        chk("score",         {16'd0, a_if.score},        {16'd0, esc});
        chk("high_score",    {16'd0, a_if.high_score},   {16'd0, ehi});
        chk("new_high",      {31'd0, a_if.new_high},     {31'd0, enh});
        chk("moles_enable",  {31'd0, a_if.moles_enable}, {31'd0, (ep == P_PLAY)});
        chk("display_value", a_if.display_value,         edisp);
    endtask

    // One clock of stimulus on instance A, with the expected post-edge outputs queued first.
    task automatic step(input logic r, input logic t, input logic s, input logic h,
                        input logic [1:0] ep, input int es, input int esc, input int ehi,
                        input logic enh);
        exp_q.push_back({ep, 6'(es), 16'(esc), 16'(ehi), enh});
        rst           = r;
        a_if.tick_1hz = t;
        a_if.start    = s;
        a_if.hit      = h;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        a_if.tick_1hz = 1'b0;
        a_if.start    = 1'b0;
        a_if.hit      = 1'b0;
        check_a();
    endtask

    task automatic step_b(input logic t, input logic s, input logic h,
                          input logic [1:0] ep, input int esc);
        logic [4:0] e;
        exp_b_q.push_back({ep, 3'(esc)});
        b_if.tick_1hz = t;
        b_if.start    = s;
        b_if.hit      = h;
        @(posedge clk);
        #1;
        b_if.tick_1hz = 1'b0;
        b_if.start    = 1'b0;
        b_if.hit      = 1'b0;
        e = exp_b_q.pop_front();
        chk("b_phase", {30'd0, b_if.phase}, {30'd0, e[4:3]});
        chk("b_score", {29'd0, b_if.score}, {29'd0, e[2:0]});
    endtask

    // Start a round from IDLE/OVER and run the countdown into PLAY with the given high score.
    task automatic run_countdown(input int hi);
        step(0, 0, 1, 0, P_CD, 5, 0, hi, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, P_CD, 4 - i, 0, hi, 0);
        step(0, 1, 0, 0, P_PLAY, 30, 0, hi, 0);
    endtask

    initial begin
        a_if.tick_1hz = 1'b0; a_if.start = 1'b0; a_if.hit = 1'b0;
        b_if.tick_1hz = 1'b0; b_if.start = 1'b0; b_if.hit = 1'b0;

        // Reset for three cycles, with a start pulse that reset must override.
        step(1, 0, 1, 0, P_IDLE, 0, 0, 0, 0);
        step(1, 0, 0, 0, P_IDLE, 0, 0, 0, 0);
        step(1, 0, 0, 0, P_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, (i % 2 == 0), P_IDLE, 0, 0, 0, 0);

        // Round 1: ignored inputs during countdown, 7 hits, start ignored in PLAY.
        step(0, 0, 1, 0, P_CD, 5, 0, 0, 0);
        step(0, 0, 0, 1, P_CD, 5, 0, 0, 0);
        step(0, 0, 1, 0, P_CD, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, P_CD, 4 - i, 0, 0, 0);
        step(0, 1, 0, 0, P_PLAY, 30, 0, 0, 0);
        for (int k = 1; k <= 7; k++) step(0, 0, 0, 1, P_PLAY, 30, k, 0, 0);
        step(0, 0, 1, 0, P_PLAY, 30, 7, 0, 0);
        for (int i = 0; i < 29; i++) step(0, 1, 0, 0, P_PLAY, 29 - i, 7, 0, 0);
        step(0, 1, 0, 0, P_OVER, 0, 7, 7, 1);
        step(0, 0, 0, 1, P_OVER, 0, 7, 7, 1);
        step(0, 1, 0, 0, P_OVER, 0, 7, 7, 1);

        // Round 2: lower score keeps the high score and clears new_high.
        run_countdown(7);
        for (int k = 1; k <= 5; k++) step(0, 0, 0, 1, P_PLAY, 30, k, 7, 0);
        for (int i = 0; i < 29; i++) step(0, 1, 0, 0, P_PLAY, 29 - i, 5, 7, 0);
        step(0, 1, 0, 0, P_OVER, 0, 5, 7, 0);

        // Round 3: a tie does not count as a new high, hits mixed with ticks.
        run_countdown(7);
        for (int k = 1; k <= 7; k++) step(0, (k == 3), 0, 1, P_PLAY, (k >= 3) ? 29 : 30, k, 7, 0);
        for (int i = 0; i < 28; i++) step(0, 1, 0, 0, P_PLAY, 28 - i, 7, 7, 0);
        step(0, 1, 0, 0, P_OVER, 0, 7, 7, 0);

        // Round 4: 8 hits, then hit and final tick together push the score to 9.
        run_countdown(7);
        for (int k = 1; k <= 8; k++) step(0, 0, 0, 1, P_PLAY, 30, k, 7, 0);
        for (int i = 0; i < 29; i++) step(0, 1, 0, 0, P_PLAY, 29 - i, 8, 7, 0);
        step(0, 1, 0, 1, P_OVER, 0, 9, 9, 1);

        // Round 5: reset mid-PLAY with score 4 wipes everything including high score.
        run_countdown(9);
        for (int k = 1; k <= 4; k++) step(0, 0, 0, 1, P_PLAY, 30, k, 9, 0);
        step(0, 1, 0, 0, P_PLAY, 29, 4, 9, 0);
        step(1, 1, 1, 1, P_IDLE, 0, 0, 0, 0);

        // Start together with a tick in IDLE begins at the full countdown.
        step(0, 1, 1, 0, P_CD, 5, 0, 0, 0);
        step(0, 1, 0, 0, P_CD, 4, 0, 0, 0);

        // 3-bit score instance: saturates at 7 instead of wrapping.
        step_b(0, 1, 0, P_CD, 0);
        step_b(1, 0, 0, P_CD, 0);
        step_b(1, 0, 0, P_PLAY, 0);
        for (int k = 1; k <= 10; k++) step_b(0, 0, 1, P_PLAY, (k > 7) ? 7 : k);
        step_b(1, 0, 1, P_PLAY, 7);
        step_b(1, 0, 0, P_PLAY, 7);
        step_b(1, 0, 0, P_OVER, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central sequencing FSM for the whack-a-mole game: it owns the idle / 5-second pre-game countdown / 30-second play / game-over phases and the per-round score and session high score. It gates the mole LEDs and selects the value sent to the BCD and seven-segment display path. Timing comes from a 1 Hz enable pulse on the system clock, not from a divided clock. Hit pulses come from the input checker.

## Interface
- COUNTDOWN_SEC, 5, pre-game countdown length in seconds (1..63)
- GAME_SEC, 30, play phase length in seconds (1..63)
- SCORE_W, 16, score and high-score width in bits (1..32)

- clk  in  1  system clock (100 MHz); all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state including high score
- tick_1hz  in  1  single-cycle enable pulse, once per second, synchronous to clk
- start  in  1  single-cycle pulse (debounced and edge-detected upstream)
- hit  in  1  single-cycle pulse per correct whack
- phase  out  2  00 COUNTDOWN, 01 PLAY, 10 OVER, 11 IDLE
- seconds_left  out  6  remaining seconds in current timed phase; 0 in IDLE/OVER
- score  out  SCORE_W  current/last round score
- high_score  out  SCORE_W  best score since reset
- new_high  out  1  high in OVER when the last round set a new high score
- moles_enable  out  1  high only in PLAY; gates mole LED drive and hit checking
- display_value  out  32  zero-extended: seconds_left in COUNTDOWN, score in PLAY and OVER, high_score in IDLE

## Operation
- Reset values: phase=11 (IDLE), seconds_left=0, score=0, high_score=0, new_high=0, moles_enable=0, display_value=0.
- IDLE: start -> COUNTDOWN. On entry, load seconds_left=COUNTDOWN_SEC, clear score, clear new_high. tick_1hz and hit are ignored.
- COUNTDOWN: each tick_1hz decrements seconds_left. A tick with seconds_left==1 goes to PLAY and loads seconds_left=GAME_SEC. hit and start are ignored.
- PLAY: each hit increments score. Score saturates at 2^SCORE_W-1 and does not wrap. Each tick decrements seconds_left. A tick with seconds_left==1 goes to OVER with seconds_left=0. start is ignored.
- OVER: score is frozen. On the entry edge, if the final score is greater than high_score, set high_score=score and new_high=1. A tie does not set new_high. start -> COUNTDOWN with the same entry actions as from IDLE; high_score is kept.
- Simultaneous hit and final tick in PLAY: the hit counts. The OVER-entry comparison uses the incremented score.
- Simultaneous start and tick in IDLE/OVER: start wins and the countdown begins at the full COUNTDOWN_SEC. The tick is dropped.
- Simultaneous hit and any tick in PLAY: both take effect in the same cycle.
- reset mid-game has priority over every input and returns to the reset values on the next edge. high_score is lost.
- State encoding uses exactly the four phase codes; unreachable encodings do not exist.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- A phase transition appears on phase/moles_enable in the cycle after the qualifying start/tick edge. seconds_left, score and display_value update on the same edge.
- hit -> score +1 visible 1 cycle later. hit pulses on consecutive cycles each count.
- OVER entry: score, high_score and new_high are all valid on the first OVER cycle, with no extra compare cycle.
- Phase durations in ticks: COUNTDOWN lasts exactly COUNTDOWN_SEC ticks; PLAY lasts exactly GAME_SEC ticks.

## Test plan
- Reset then idle: hold reset 3 cycles, then apply 10 ticks with no start -> phase=11, all outputs 0 throughout.
- Full round: start, then 5 ticks -> PLAY with seconds_left=30, moles_enable=1. Apply 7 hits, then 30 ticks -> phase=10, score=7, high_score=7, new_high=1, display_value=7, moles_enable=0.
- Second round lower/tie: start from OVER, then a 5-hit round -> OVER with score=5, high_score=7, new_high=0. Repeat with a 7-hit round -> new_high=0, high_score=7.
- Boundary: in PLAY with seconds_left=1, assert hit and tick in the same cycle -> next cycle phase=10 and the score includes the hit. Also assert start and tick together in IDLE -> seconds_left=5 (not 4).
- Ignored inputs and saturation: hits during COUNTDOWN/OVER and start during PLAY have no effect. With SCORE_W=3, apply 10 hits -> score=7 (no wrap).
- Reset mid-PLAY with score=4 and high_score=9 -> next cycle phase=11, score=0, high_score=0, seconds_left=0.
